// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer: record layout, kinds and packing.
package commit_trace_buffer_pkg;

  localparam int SEQ_W  = 8;
  localparam int PC_W   = 12;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RFA_W  = 5;
  localparam int REC_W  = 66;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_REG  = 2'b01,
    KIND_MEM  = 2'b10
  } kind_e;

  // Field order fixes the wire layout: {seq, kind, pc, addr, data}, MSB first.
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    kind_e             kind;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_rec_t;

  function automatic logic [REC_W-1:0] packRecord(
    input logic [SEQ_W-1:0]  seq,
    input kind_e             kind,
    input logic [PC_W-1:0]   pc,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    trace_rec_t rec;
    rec.seq  = seq;
    rec.kind = kind;
    rec.pc   = pc;
    rec.addr = addr;
    rec.data = data;
    return rec;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Record FIFO with up to two pushes and one pop per cycle. The caller
// guarantees there is room for whatever it pushes and only asserts push1_i
// together with push0_i.
module commit_trace_buffer_fifo
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push0_i,
  input  logic                   push1_i,
  input  logic [REC_W-1:0]       rec0_i,
  input  logic [REC_W-1:0]       rec1_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [REC_W-1:0]       head_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      level_q, level_d;
  logic             popFire;
  logic [1:0]       pushCount;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    popFire   = pop_i & (level_q != '0);
    pushCount = {1'b0, push0_i} + {1'b0, push1_i};
    wrPtr_d   = wrPtr_q + AW'(pushCount);
    rdPtr_d   = rdPtr_q + AW'(popFire);
    level_d   = level_q + (AW+1)'(pushCount) - (AW+1)'(popFire);
  end

  // Pointer and occupancy registers; reset discards every queued record.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage write; the second record lands in the slot after the first so it drains later.
  always_ff @(posedge clock) begin
    if (push0_i) mem_q[wrPtr_q] <= rec0_i;
    if (push1_i) mem_q[wrPtr_q + AW'(1)] <= rec1_i;
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  always_comb begin
    valid_o = (level_q != '0);
    head_o  = valid_o ? mem_q[rdPtr_q] : '0;
    level_o = level_q;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: qualifies register/memory commits, packs them into
// sequence-numbered records and queues them for a valid/ready consumer.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PC_W-1:0]        pc,
  input  logic                   rf_we,
  input  logic [RFA_W-1:0]       rf_waddr,
  input  logic [DATA_W-1:0]      rf_wdata,
  input  logic                   dm_we,
  input  logic [ADDR_W-1:0]      dm_addr,
  input  logic [DATA_W-1:0]      dm_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REC_W-1:0]       out_data,
  output logic [15:0]            drop_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic             regEvent, memEvent;
  logic [1:0]       need;
  logic [LW-1:0]    freeSlots;
  logic             accept, dropCycle;
  logic             push0, push1;
  logic [REC_W-1:0] rec0, rec1;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [15:0]      dropCount_q, dropCount_d;

  // Decide what this cycle commits: all events fit in the space held at the
  // start of the cycle, or the whole cycle is dropped.
  always_comb begin
    regEvent  = enable & rf_we & (rf_waddr != '0);
    memEvent  = enable & dm_we;
    need      = {1'b0, regEvent} + {1'b0, memEvent};
    freeSlots = LW'(DEPTH) - level;
    accept    = (need != 2'd0) && (freeSlots >= LW'(need));
    dropCycle = (need != 2'd0) && !accept;
    push0     = accept;
    push1     = accept & regEvent & memEvent;
    rec0 = regEvent
         ? packRecord(seq_q, KIND_REG, pc, ADDR_W'(rf_waddr), rf_wdata)
         : packRecord(seq_q, KIND_MEM, pc, dm_addr, dm_wdata);
    rec1 = packRecord(seq_q + SEQ_W'(1), KIND_MEM, pc, dm_addr, dm_wdata);
    seq_d       = accept ? seq_q + SEQ_W'(need) : seq_q;
    dropCount_d = (dropCycle && dropCount_q != 16'hFFFF) ? dropCount_q + 16'd1 : dropCount_q;
  end

  // Sequence number and saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq_q       <= '0;
      dropCount_q <= '0;
    end else begin
      seq_q       <= seq_d;
      dropCount_q <= dropCount_d;
    end
  end

  commit_trace_buffer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push0_i (push0),
    .push1_i (push1),
    .rec0_i  (rec0),
    .rec1_i  (rec1),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .head_o  (out_data),
    .level_o (level)
  );

  assign drop_count = dropCount_q;

endmodule
